cskipa_57bit_stream: RTL

Streaming front/back end for the 57-bit carry-skip adder (`CSkipA_57bit`). It accepts operand pairs through a valid/ready handshake and buffers them in a small FIFO. It presents the FIFO head to an internal `CSkipA_57bit` instance, then captures sum and carry-out in a registered output stage with its own valid/ready handshake. It is the stage that feeds the adder and consumes its result, so batch adder benches can drive back-to-back traffic with backpressure.

---
 rtl/cskipa_57bit_stream.sv | 107 ++++++++++
 1 files changed

// File: rtl/cskipa_57bit_stream.sv
// cskipa_57bit_stream: operand FIFO feeding a carry-skip adder with a registered valid/ready result stage
module CSkipA_57bit #(
    parameter int WIDTH = 57,
    parameter int BLK   = 4
) (
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    localparam int NB = (WIDTH + BLK - 1) / BLK;
    localparam int PW = NB * BLK;
    logic [PW-1:0] p, g;
    logic c, cb;
    for (genvar i = 0; i < PW; i++) begin : g_pg
        // pad bits propagate so the last partial block skips and ripples correctly
        if (i < WIDTH) begin : g_real
            assign p[i] = i_add_term1[i] ^ i_add_term2[i];
            assign g[i] = i_add_term1[i] & i_add_term2[i];
        end else begin : g_pad
            assign p[i] = 1'b1;
            assign g[i] = 1'b0;
        end
    end
    always_comb begin
        o_sum = '0;
        c = i_cin;
        cb = i_cin;
        for (int k = 0; k < NB; k++) begin
            cb = c;
            for (int j = 0; j < BLK; j++) begin
                if (k * BLK + j < WIDTH) o_sum[k*BLK+j] = p[k*BLK+j] ^ c;
                c = g[k*BLK+j] | (p[k*BLK+j] & c);
            end
            c = (&p[k*BLK +: BLK]) ? cb : c;
        end
        o_cout = c;
    end
endmodule

module cskipa_57bit_stream #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [WIDTH-1:0]         i_add_term1,
    input  logic [WIDTH-1:0]         i_add_term2,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_sum,
    output logic                     o_cout,
    output logic [15:0]              o_count,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    logic [WIDTH-1:0] mem_a [DEPTH];
    logic [WIDTH-1:0] mem_b [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [WIDTH-1:0] add_sum;
    logic add_cout, push, load, take;
    assign o_ready = !i_rst && (o_level != LW'(DEPTH));
    assign push = i_valid && o_ready;
    assign load = (o_level != '0) && (!o_valid || i_ready);
    assign take = o_valid && i_ready;
    CSkipA_57bit #(.WIDTH(WIDTH)) u_add (
        .i_add_term1(mem_a[rp]),
        .i_add_term2(mem_b[rp]),
        .i_cin      (1'b0),
        .o_sum      (add_sum),
        .o_cout     (add_cout)
    );
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_a[wp] <= i_add_term1;
            mem_b[wp] <= i_add_term2;
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wp      <= '0;
            rp      <= '0;
            o_level <= '0;
            o_valid <= 1'b0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
            o_count <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (load) begin
                rp      <= rp + 1'b1;
                o_sum   <= add_sum;
                o_cout  <= add_cout;
                o_valid <= 1'b1;
            end else if (take) begin
                o_valid <= 1'b0;
            end
            if (push && !load) o_level <= o_level + 1'b1;
            else if (load && !push) o_level <= o_level - 1'b1;
            if (take) o_count <= o_count + 16'd1;
        end
    end
endmodule
